dmem_bus_arbiter: RTL and testbench

//  Shares the single data-memory/IO port (DMemory_IO) between the LEGLiteSingle CPU and a debug/loader requester.
//  The CPU has priority; the debug port is granted on cycles where the CPU makes no access.
//  If the debug port waits MAX_WAIT cycles, the arbiter forces a one-cycle CPU stall and grants the debug port.

---
 rtl/dmem_bus_arbiter_pkg.sv | 19 +
 rtl/dmem_bus_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bus_arbiter_pkg.sv
// rtl/dmem_bus_arbiter_pkg.sv - shared types and defaults for the data-memory bus arbiter
package dmem_bus_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W      = 16;
  localparam int WAIT_W     = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } arb_state_t;

  // Saturating increment used for the forced-stall counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/dmem_bus_arbiter.sv
// rtl/dmem_bus_arbiter.sv - CPU-priority arbiter for the data-memory port with forced debug stalls
module dmem_bus_arbiter
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_draddr,
  input  logic [DATA_W-1:0] cpu_dwdata,
  input  logic              cpu_dwrite,
  input  logic              cpu_dread,
  output logic [DATA_W-1:0] cpu_drdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  arb_state_t        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              cpu_acc;
  logic              in_stall;

  assign cpu_acc    = cpu_dread | cpu_dwrite;
  assign in_stall   = (state == ST_STALL);
  assign cpu_stall  = in_stall;
  assign cpu_drdata = mem_rdata;

  // Grant is gated by reset so a reset landing mid-stall cannot complete a debug access.
  always_comb begin
    state_nxt    = ST_IDLE;
    wait_cnt_nxt = '0;
    dbg_gnt      = 1'b0;
    case (state)
      ST_IDLE: begin
        dbg_gnt = reset_n & dbg_req & ~cpu_acc;
        if (dbg_req && !dbg_gnt) begin
          wait_cnt_nxt = wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        dbg_gnt = reset_n & dbg_req;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Zero-latency port mux; in the stall cycle the CPU strobes never reach memory.
  always_comb begin
    mem_addr  = cpu_draddr;
    mem_wdata = cpu_dwdata;
    mem_write = cpu_dwrite;
    mem_read  = cpu_dread;
    if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_write = dbg_we;
      mem_read  = ~dbg_we;
    end else if (in_stall) begin
      mem_write = 1'b0;
      mem_read  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      dbg_rvalid  <= 1'b0;
      dbg_rdata   <= '0;
      stall_count <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (dbg_gnt && !dbg_we) begin
        dbg_rdata <= mem_rdata;
      end
      if (in_stall) begin
        stall_count <= sat_inc(stall_count);
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb/tb_dmem_bus_arbiter.sv - self-checking bench for dmem_bus_arbiter
module tb_dmem_bus_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_draddr = '0;
  logic [15:0] cpu_dwdata = '0;
  logic        cpu_dwrite = 1'b0;
  logic        cpu_dread = 1'b0;
  logic [15:0] cpu_drdata;
  logic        cpu_stall;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [15:0] dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic        dbg_gnt;
  logic [15:0] dbg_rdata;
  logic        dbg_rvalid;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_rdata;
  logic [15:0] stall_count;

  always #5 clock = ~clock;

  dmem_bus_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_draddr(cpu_draddr), .cpu_dwdata(cpu_dwdata), .cpu_dwrite(cpu_dwrite),
    .cpu_dread(cpu_dread), .cpu_drdata(cpu_drdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .stall_count(stall_count)
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return {a, ~a};
  endfunction

  // Memory seen by the DUT: combinational read, write at the rising edge.
  logic [15:0] env_mem [256];
  bit          env_wr  [256];
  assign mem_rdata = env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
  always @(posedge clock) begin
    if (mem_write) begin
      env_mem[mem_addr[7:0]] <= mem_wdata;
      env_wr[mem_addr[7:0]]  <= 1'b1;
    end
  end

  // Reference state: what memory and the arbiter outputs must be.
  logic [15:0] ref_mem [256];
  bit          ref_wr  [256];
  logic        m_stall = 1'b0;
  int          m_pend = 0;
  logic        m_rvalid = 1'b0;
  logic [15:0] m_rdata = '0;
  logic [15:0] m_count = '0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic        obs_stall, obs_gnt, obs_rvalid;
  logic [15:0] obs_drdata, obs_rdata, obs_cnt;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_wr[a[7:0]] ? ref_mem[a[7:0]] : init_val(a[7:0]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    logic acc, st, g, wr, rd, addr_valid;
    logic [15:0] a, wd, rv;
    acc = cpu_dread | cpu_dwrite;
    st  = reset_n && m_stall;
    g   = reset_n && dbg_req && (st || !acc);
    if (g) begin
      a = dbg_addr; wd = dbg_wdata; wr = dbg_we; rd = !dbg_we;
    end else if (st) begin
      a = cpu_draddr; wd = cpu_dwdata; wr = 1'b0; rd = 1'b0;
    end else begin
      a = cpu_draddr; wd = cpu_dwdata; wr = cpu_dwrite; rd = cpu_dread;
    end
    addr_valid = wr || rd || !st;
    rv = ref_rd(a);
    chk("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, g});
    chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, st});
    chk("mem_write", {31'd0, mem_write}, {31'd0, wr});
    chk("mem_read", {31'd0, mem_read}, {31'd0, rd});
    if (addr_valid) begin
      chk("mem_addr", {16'd0, mem_addr}, {16'd0, a});
      chk("cpu_drdata", {16'd0, cpu_drdata}, {16'd0, rv});
    end
    if (wr) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, wd});
    chk("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, reset_n ? m_rvalid : 1'b0});
    chk("dbg_rdata", {16'd0, dbg_rdata}, {16'd0, reset_n ? m_rdata : 16'd0});
    chk("stall_count", {16'd0, stall_count}, {16'd0, reset_n ? m_count : 16'd0});
    if (wr) begin
      ref_mem[a[7:0]] = wd;
      ref_wr[a[7:0]]  = 1'b1;
    end
    if (!reset_n) begin
      m_stall = 1'b0; m_pend = 0; m_rvalid = 1'b0; m_rdata = '0; m_count = '0;
    end else begin
      m_rvalid = g && !dbg_we;
      if (m_rvalid) m_rdata = rv;
      if (st && m_count != 16'hFFFF) m_count = m_count + 16'd1;
      // A debug request left waiting for MAX_WAIT consecutive cycles forces the next cycle.
      if (!st && dbg_req && !g) m_pend = m_pend + 1;
      else m_pend = 0;
      m_stall = (m_pend == MAX_WAIT);
      if (m_stall) m_pend = 0;
    end
  endtask

  task automatic set_cpu(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    cpu_dread = rd; cpu_dwrite = wr; cpu_draddr = a; cpu_dwdata = d;
  endtask

  task automatic set_dbg(input logic rq, input logic we, input logic [15:0] a, input logic [15:0] d);
    dbg_req = rq; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic step(input logic rst_mid);
    #2;
    if (rst_mid) reset_n = 1'b0;
    @(negedge clock);
    model_cycle();
    obs_stall = cpu_stall; obs_gnt = dbg_gnt; obs_drdata = cpu_drdata;
    obs_rvalid = dbg_rvalid; obs_rdata = dbg_rdata; obs_cnt = stall_count;
    cyc++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    @(posedge clock);
    #1;
    // Reset held for two cycles.
    reset_n = 1'b0;
    repeat (2) step(1'b0);
    chk("rst_stall_count", {16'd0, obs_cnt}, 32'd0);
    chk("rst_cpu_stall", {31'd0, obs_stall}, 32'd0);
    reset_n = 1'b1;

    // CPU read passes memory data straight through.
    set_cpu(1'b1, 1'b0, 16'h0004, 16'h0000);
    step(1'b0);
    chk("t1_drdata", {16'd0, obs_drdata}, 32'h04FB);

    // Idle CPU: debug write then read back.
    set_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_dbg(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b0);
    chk("t2_wr_gnt", {31'd0, obs_gnt}, 32'd1);
    set_dbg(1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0);
    set_dbg(1'b1, 1'b0, 16'h0010, 16'h0000);
    step(1'b0);
    chk("t2_rd_gnt", {31'd0, obs_gnt}, 32'd1);
    set_dbg(1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0);
    chk("t2_rvalid", {31'd0, obs_rvalid}, 32'd1);
    chk("t2_rdata", {16'd0, obs_rdata}, 32'hBEEF);
    step(1'b0);
    chk("t2_rvalid_drop", {31'd0, obs_rvalid}, 32'd0);

    // CPU writes every cycle; debug write forced through in cycle 4.
    set_dbg(1'b1, 1'b1, 16'h0040, 16'hD00D);
    for (int i = 0; i < 5; i++) begin
      set_cpu(1'b0, 1'b1, 16'h0030 + 16'(i), 16'hC000 + 16'(i));
      step(1'b0);
      chk("t3_stall", {31'd0, obs_stall}, (i == 4) ? 32'd1 : 32'd0);
      chk("t3_gnt", {31'd0, obs_gnt}, (i == 4) ? 32'd1 : 32'd0);
    end
    set_dbg(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_cpu(1'b1, 1'b0, 16'h0034, 16'h0000);
    step(1'b0);
    chk("t3_count", {16'd0, obs_cnt}, 32'd1);
    chk("t3_blocked_wr", {16'd0, obs_drdata}, 32'h34CB);
    set_cpu(1'b1, 1'b0, 16'h0033, 16'h0000);
    step(1'b0);
    chk("t3_cpu_wr", {16'd0, obs_drdata}, 32'hC003);
    set_cpu(1'b1, 1'b0, 16'h0040, 16'h0000);
    step(1'b0);
    chk("t3_dbg_wr", {16'd0, obs_drdata}, 32'hD00D);

    // Withdrawn request: no stall.
    set_dbg(1'b1, 1'b0, 16'h0050, 16'h0000);
    set_cpu(1'b1, 1'b0, 16'h0060, 16'h0000);
    repeat (2) step(1'b0);
    set_dbg(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      chk("t4_no_stall", {31'd0, obs_stall}, 32'd0);
    end
    chk("t4_count", {16'd0, obs_cnt}, 32'd1);

    // Continuous debug pressure against a busy CPU.
    reset_n = 1'b0;
    step(1'b0);
    reset_n = 1'b1;
    set_dbg(1'b1, 1'b0, 16'h0010, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      set_cpu(1'b0, 1'b1, 16'h0070 + 16'(i % 4), 16'hA000 + 16'(i));
      step(1'b0);
      chk("t5_stall", {31'd0, obs_stall}, (i % 5 == 4) ? 32'd1 : 32'd0);
    end
    set_dbg(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0);
    chk("t5_count", {16'd0, obs_cnt}, 32'd4);

    // Reset landing inside the stall cycle.
    set_dbg(1'b1, 1'b1, 16'h0020, 16'h1234);
    set_cpu(1'b1, 1'b0, 16'h0060, 16'h0000);
    repeat (4) step(1'b0);
    step(1'b1);
    chk("t6_stall_drop", {31'd0, obs_stall}, 32'd0);
    chk("t6_count", {16'd0, obs_cnt}, 32'd0);
    step(1'b0);
    reset_n = 1'b1;
    set_dbg(1'b0, 1'b0, 16'h0000, 16'h0000);
    set_cpu(1'b1, 1'b0, 16'h0020, 16'h0000);
    step(1'b0);
    chk("t6_no_write", {16'd0, obs_drdata}, 32'h20DF);
    chk("t6_idle", {31'd0, obs_stall}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
